// File: rtl/if_fetch_stage_pkg.sv
// Shared widths and stall encodings for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int unsigned STALL_BUS_WD = 6;
    localparam int unsigned BR_WD        = 33;
    localparam int unsigned IF_TO_ID_WD  = 33;

    // stall[0] encodings
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM, holds one pending
// redirect across stalls and flags misaligned fetch addresses.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [BR_WD-1:0]        br_bus,
    output logic [IF_TO_ID_WD-1:0]  if_to_id_bus,
    output logic                    inst_sram_en,
    output logic [3:0]              inst_sram_wen,
    output logic [31:0]             inst_sram_addr,
    output logic [31:0]             inst_sram_wdata,
    output logic                    fetch_adel,
    output logic [31:0]             fetch_count
);

    logic [31:0] pc_r;
    logic        ce_r;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic [31:0] fetch_count_r;

    br_bus_t     br;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        stop;

    // Only stall[0] matters here; upper bits belong to later stages.
    logic unused_stall;
    assign unused_stall = ^stall[STALL_BUS_WD-1:1];

    assign br   = br_bus_t'(br_bus);
    assign stop = (stall[0] == STOP);

    // Next-PC select: live redirect beats a pending one, which beats sequential.
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br.br_e) begin
            next_pc = br.br_addr;
        end else if (pend_v) begin
            next_pc = pend_addr;
        end
    end

    // PC, fetch-enable, pending-redirect latch and fetch counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r          <= RESET_VECTOR - 32'd4;
            ce_r          <= 1'b0;
            pend_v        <= 1'b0;
            pend_addr     <= 32'd0;
            fetch_count_r <= 32'd0;
        end else begin
            if (!stop) begin
                ce_r   <= 1'b1;
                pc_r   <= next_pc;
                pend_v <= 1'b0;
                if (inst_sram_en) begin
                    fetch_count_r <= fetch_count_r + 32'd1;
                end
            end else if (br.br_e) begin
                // Latest redirect seen during a stall wins.
                pend_v    <= 1'b1;
                pend_addr <= br.br_addr;
            end
        end
    end

    // SRAM interface and decode-facing outputs, all combinational from state.
    always_comb begin
        misaligned      = (pc_r[1:0] != 2'b00);
        inst_sram_en    = ce_r & ~misaligned;
        inst_sram_wen   = 4'b0000;
        inst_sram_addr  = pc_r;
        inst_sram_wdata = 32'd0;
        fetch_adel      = ce_r & misaligned;
        fetch_count     = fetch_count_r;
        // Bus reads all-zero while reset is held, not {0, RESET_VECTOR-4}.
        if_to_id_bus    = resetn ? {ce_r, pc_r} : '0;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic                    clk;
    logic                    resetn;
    logic [STALL_BUS_WD-1:0] stall;
    logic [BR_WD-1:0]        br_bus;
    logic [IF_TO_ID_WD-1:0]  if_to_id_bus;
    logic                    inst_sram_en;
    logic [3:0]              inst_sram_wen;
    logic [31:0]             inst_sram_addr;
    logic [31:0]             inst_sram_wdata;
    logic                    fetch_adel;
    logic [31:0]             fetch_count;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(.RESET_VECTOR(32'hBFC0_0000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .fetch_adel      (fetch_adel),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks address, ce and count in one go.
    task automatic expect_fetch(input string tag, input logic [31:0] addr,
                                input logic [31:0] cnt);
        check({tag, "_addr"}, 64'(inst_sram_addr), 64'(addr));
        check({tag, "_bus"}, 64'(if_to_id_bus), 64'({1'b1, addr}));
        check({tag, "_cnt"}, 64'(fetch_count), 64'(cnt));
        check({tag, "_wen"}, 64'(inst_sram_wen), 64'(0));
        check({tag, "_wdata"}, 64'(inst_sram_wdata), 64'(0));
    endtask

    initial begin
        resetn = 1'b0;
        stall  = '0;
        br_bus = '0;

        // Reset state
        #12;
        check("rst_bus", 64'(if_to_id_bus), 64'(0));
        check("rst_en", 64'(inst_sram_en), 64'(0));
        check("rst_adel", 64'(fetch_adel), 64'(0));
        check("rst_cnt", 64'(fetch_count), 64'(0));
        resetn = 1'b1;

        // 1. sequential fetch from reset vector
        step(); expect_fetch("seq0", 32'hBFC0_0000, 32'd0);
        check("seq0_en", 64'(inst_sram_en), 64'(1));
        step(); expect_fetch("seq1", 32'hBFC0_0004, 32'd1);
        step(); expect_fetch("seq2", 32'hBFC0_0008, 32'd2);

        // 2. unstalled redirect
        br_bus = {1'b1, 32'hBFC0_0100};
        step(); expect_fetch("br0", 32'hBFC0_0100, 32'd3);
        br_bus = '0;
        step(); expect_fetch("br1", 32'hBFC0_0104, 32'd4);

        // 3. three stalled cycles, two redirects during stall
        stall  = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0100};
        step(); expect_fetch("st0", 32'hBFC0_0104, 32'd4);
        br_bus = {1'b1, 32'hBFC0_0200};
        step(); expect_fetch("st1", 32'hBFC0_0104, 32'd4);
        br_bus = '0;
        step(); expect_fetch("st2", 32'hBFC0_0104, 32'd4);
        stall  = '0;
        step(); expect_fetch("st_rel", 32'hBFC0_0200, 32'd5);
        step(); expect_fetch("st_clr", 32'hBFC0_0204, 32'd6);

        // 4. misaligned target
        br_bus = {1'b1, 32'hBFC0_0102};
        step(); expect_fetch("mis0", 32'hBFC0_0102, 32'd7);
        check("mis0_adel", 64'(fetch_adel), 64'(1));
        check("mis0_en", 64'(inst_sram_en), 64'(0));
        br_bus = '0;
        step(); expect_fetch("mis1", 32'hBFC0_0106, 32'd7);
        check("mis1_adel", 64'(fetch_adel), 64'(1));
        br_bus = {1'b1, 32'hBFC0_0200};
        step(); expect_fetch("mis2", 32'hBFC0_0200, 32'd7);
        check("mis2_adel", 64'(fetch_adel), 64'(0));
        check("mis2_en", 64'(inst_sram_en), 64'(1));

        // 5. reset while stalled with a pending redirect
        stall  = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0300};
        step(); expect_fetch("pr0", 32'hBFC0_0200, 32'd7);
        br_bus = '0;
        #1 resetn = 1'b0;
        #1;
        check("ar_bus", 64'(if_to_id_bus), 64'(0));
        check("ar_en", 64'(inst_sram_en), 64'(0));
        check("ar_adel", 64'(fetch_adel), 64'(0));
        check("ar_cnt", 64'(fetch_count), 64'(0));
        step();
        check("ar_hold_bus", 64'(if_to_id_bus), 64'(0));
        resetn = 1'b1;
        stall  = '0;
        step(); expect_fetch("rr0", 32'hBFC0_0000, 32'd0);
        step(); expect_fetch("rr1", 32'hBFC0_0004, 32'd1);

        // 6. PC wrap
        br_bus = {1'b1, 32'hFFFF_FFFC};
        step(); expect_fetch("wr0", 32'hFFFF_FFFC, 32'd2);
        br_bus = '0;
        step(); expect_fetch("wr1", 32'h0000_0000, 32'd3);
        step(); expect_fetch("wr2", 32'h0000_0004, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
